tone_arbiter: RTL and testbench
===============================

// Module: tone_arbiter
// PURPOSE
//  Owns the shared buzzer tone generator and decides which note it plays each cycle.
//  Three requesters compete for it: key clicks, win/lose jingles and background game music.
//  Sits between the game FSM/keypad and the tone divider block.
//  Emits one registered note code per cycle (0 = silence), plus the winning source.
// PARAMETERS
//  TICK_DIV  27000  clk cycles per 1 ms timer tick (27 MHz clk)
//  CLICK_MS  100    click note length, ms
//  NOTE_MS   150    length of each jingle note, ms
//  GAP_MS    20     silence between jingle notes, ms (only with TONE_ARB_GAP_EN)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  synchronous active-low reset
//  key_pressed  in   1  keypad pressed level; a click fires on its rising edge
//  jingle_req   in   1  1-cycle pulse: start the jingle chosen by jingle_sel
//  jingle_sel   in   2  sampled with jingle_req: 01 = win, 10 = lose, 00/11 = ignore request
//  music_en     in   1  high while the game FSM is in the GAME state
//  music_note   in   3  current background note code from the sequencer
//  note_out     out  3  note code to the tone divider (0 = silent)
//  active_src   out  2  source of note_out: 0 none, 1 music, 2 click, 3 jingle
//  busy         out  1  high in CLICK or JINGLE
//  jingle_done  out  1  1-cycle pulse after the last jingle note ends
// BEHAVIOUR
//  Reset: state=IDLE; note_out=0, active_src=0, busy=0, jingle_done=0; key edge reg=0.
//  Priority: JINGLE > CLICK > MUSIC.
//  Outputs are registered: note_out updates on the edge after the triggering input is sampled.
//  FSM states:
//   IDLE:
//    - valid jingle_req -> JINGLE
//    - else key rise -> CLICK
//    - else note_out = music_en ? music_note : 0; active_src = music_en ? 1 : 0
//   CLICK:
//    - note_out = FA for exactly CLICK_MS*TICK_DIV cycles, then -> IDLE
//    - another key rise in CLICK restarts the timer (no extra IDLE cycle)
//    - valid jingle_req aborts the click -> JINGLE
//   JINGLE:
//    - plays 4 notes of NOTE_MS each, then -> IDLE with jingle_done=1 for one cycle
//    - win = DO,FA,SOL,SIB; lose = SOL,FA,RE,DO
//    - key rise is ignored (no click is queued)
//    - a new valid jingle_req restarts at note 0 with the new selection
//  Timers:
//   - ms prescaler (0..TICK_DIV-1) and ms counter both clear on every state entry or restart
//   - so all durations are exact cycle multiples
//   - prescaler wraps at TICK_DIV-1; ms counter is 16 bits, no saturation needed
//  Simultaneous events:
//   - jingle_req and key rise in the same cycle -> JINGLE, click dropped
//   - music input is ignored whenever busy=1
//  music_en low while idle: note_out=0 on the next cycle.
// CONFIGURATION
//  TONE_ARB_GAP_EN defined:
//   - GAP_MS of note 0 after each jingle note except the last
//   - total jingle = 4*NOTE_MS + 3*GAP_MS
//  TONE_ARB_GAP_EN undefined:
//   - notes are back to back, total = 4*NOTE_MS; GAP_MS is unused
// STRUCTURE
//  Shared package sonido_pkg holds:
//   - note codes: FA=1, RE=2, SOL=3, DO=4, SIB=5, SIL=0
//   - game-state codes: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5
//   - arb_state_t (IDLE/CLICK/JINGLE), source codes, and both jingle note tables
//  Sub-module ms_tick_gen:
//   - prescaler with sync clear input, 1-cycle tick output, parameter TICK_DIV
// TESTING (bench uses TICK_DIV=10, CLICK_MS=5, NOTE_MS=3, GAP_MS=2)
//  1. music_en=1, music_note=3, idle -> note_out=3, src=1 next cycle; music_en=0 -> note_out=0.
//  2. key rise -> note_out=1, src=2, busy=1 for 50 cycles, then music resumes; held key makes no 2nd click.
//  3. jingle_req, sel=01 -> notes 4,1,3,5 at 30 cycles each; jingle_done pulses once; sel=11 -> no change.
//  4. key rise at cycle 20 of a click, then jingle_req -> click restarts 50 cycles, then jingle aborts it.
//  5. key rise during jingle -> ignored; jingle_req+key same cycle -> JINGLE only.
//  6. rst_n=0 mid-jingle -> all outputs 0 next edge; with TONE_ARB_GAP_EN, 20-cycle zeros between notes.

Source files
------------

// File: rtl/sonido_pkg.sv
// Shared buzzer definitions: note codes, game states, arbiter states, jingle tables.
// Imported by the tone arbiter and its timer.
package sonido_pkg;

  localparam logic [2:0] SIL = 3'd0;
  localparam logic [2:0] FA  = 3'd1;
  localparam logic [2:0] RE  = 3'd2;
  localparam logic [2:0] SOL = 3'd3;
  localparam logic [2:0] DO  = 3'd4;
  localparam logic [2:0] SIB = 3'd5;

  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] WLCM = 3'd1;
  localparam logic [2:0] CH   = 3'd2;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CLICK,
    JINGLE
  } arb_state_t;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_MUSIC  = 2'd1;
  localparam logic [1:0] SRC_CLICK  = 2'd2;
  localparam logic [1:0] SRC_JINGLE = 2'd3;

  // Note 0 sits in the low bits
  localparam logic [11:0] WIN_TBL  = {SIB, SOL, FA, DO};
  localparam logic [11:0] LOSE_TBL = {DO, RE, FA, SOL};

  function automatic logic [2:0] jingle_note(
    input logic       win,
    input logic [1:0] idx
  );
    logic [11:0] tbl;
    tbl = win ? WIN_TBL : LOSE_TBL;
    return tbl[3*idx +: 3];
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts clk cycles and pulses tick on the last one.
// A synchronous clear restarts the count from zero.
module ms_tick_gen #(
  parameter int TICK_DIV = 27000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr || presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/tone_arbiter.sv
// Buzzer note arbiter: jingle > click > music, registered note/source outputs.
// Define TONE_ARB_GAP_EN to insert GAP_MS of silence between jingle notes.
import sonido_pkg::*;

module tone_arbiter #(
  parameter int TICK_DIV = 27000,
  parameter int CLICK_MS = 100,
  parameter int NOTE_MS  = 150,
  parameter int GAP_MS   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_pressed,
  input  logic       jingle_req,
  input  logic [1:0] jingle_sel,
  input  logic       music_en,
  input  logic [2:0] music_note,
  output logic [2:0] note_out,
  output logic [1:0] active_src,
  output logic       busy,
  output logic       jingle_done
);

`ifdef TONE_ARB_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  localparam logic [15:0] CLICK_LAST = 16'(CLICK_MS - 1);
  localparam logic [15:0] NOTE_LAST  = 16'(NOTE_MS - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_MS - 1);

  arb_state_t  state, state_n;
  logic        key_q;
  logic        win, win_n;
  logic [1:0]  idx, idx_n;
  logic        gap, gap_n;
  logic [15:0] ms_cnt;
  logic        tick;
  logic        tmr_clr;
  logic        done_n;
  logic        key_rise;
  logic        jreq_ok;
  logic [2:0]  note_n;
  logic [1:0]  src_n;

  assign key_rise = key_pressed & ~key_q;
  assign jreq_ok  = jingle_req &
                    (jingle_sel == 2'b01 || jingle_sel == 2'b10);

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms_cnt <= '0;
    end else if (tmr_clr) begin
      ms_cnt <= '0;
    end else if (tick) begin
      ms_cnt <= ms_cnt + 16'd1;
    end
  end

  always_comb begin
    state_n = state;
    win_n   = win;
    idx_n   = idx;
    gap_n   = gap;
    tmr_clr = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (jreq_ok) begin
          state_n = JINGLE;
          win_n   = (jingle_sel == 2'b01);
          idx_n   = 2'd0;
          gap_n   = 1'b0;
          tmr_clr = 1'b1;
        end else if (key_rise) begin
          state_n = CLICK;
          tmr_clr = 1'b1;
        end
      end
      CLICK: begin
        if (jreq_ok) begin
          state_n = JINGLE;
          win_n   = (jingle_sel == 2'b01);
          idx_n   = 2'd0;
          gap_n   = 1'b0;
          tmr_clr = 1'b1;
        end else if (key_rise) begin
          tmr_clr = 1'b1;
        end else if (tick && ms_cnt == CLICK_LAST) begin
          state_n = IDLE;
          tmr_clr = 1'b1;
        end
      end
      JINGLE: begin
        if (jreq_ok) begin
          win_n   = (jingle_sel == 2'b01);
          idx_n   = 2'd0;
          gap_n   = 1'b0;
          tmr_clr = 1'b1;
        end else if (GAP_ON && gap) begin
          if (tick && ms_cnt == GAP_LAST) begin
            gap_n   = 1'b0;
            idx_n   = idx + 2'd1;
            tmr_clr = 1'b1;
          end
        end else if (tick && ms_cnt == NOTE_LAST) begin
          tmr_clr = 1'b1;
          if (idx == 2'd3) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (GAP_ON) begin
            gap_n = 1'b1;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs follow the state being entered, so they land on the same edge
  always_comb begin
    note_n = SIL;
    src_n  = SRC_NONE;
    unique case (state_n)
      IDLE: begin
        note_n = music_en ? music_note : SIL;
        src_n  = music_en ? SRC_MUSIC : SRC_NONE;
      end
      CLICK: begin
        note_n = FA;
        src_n  = SRC_CLICK;
      end
      JINGLE: begin
        note_n = gap_n ? SIL : jingle_note(win_n, idx_n);
        src_n  = SRC_JINGLE;
      end
      default: begin
        note_n = SIL;
        src_n  = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_q       <= 1'b0;
      win         <= 1'b0;
      idx         <= 2'd0;
      gap         <= 1'b0;
      note_out    <= SIL;
      active_src  <= SRC_NONE;
      busy        <= 1'b0;
      jingle_done <= 1'b0;
    end else begin
      state       <= state_n;
      key_q       <= key_pressed;
      win         <= win_n;
      idx         <= idx_n;
      gap         <= gap_n;
      note_out    <= note_n;
      active_src  <= src_n;
      busy        <= (state_n != IDLE);
      jingle_done <= done_n;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Randomised scoreboard bench for tone_arbiter with a segment-queue reference model.
// Honours TONE_ARB_GAP_EN the same way as the design.
module tb_tone_arbiter;

  localparam int TD      = 10;
  localparam int C_MS    = 5;
  localparam int N_MS    = 3;
  localparam int G_MS    = 2;
  localparam int CLK_LEN = C_MS * TD;
  localparam int NOT_LEN = N_MS * TD;
  localparam int GAP_LEN = G_MS * TD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_pressed = 1'b0;
  logic       jingle_req = 1'b0;
  logic [1:0] jingle_sel = 2'b00;
  logic       music_en = 1'b0;
  logic [2:0] music_note = 3'd0;
  logic [2:0] note_out;
  logic [1:0] active_src;
  logic       busy;
  logic       jingle_done;

  tone_arbiter #(
    .TICK_DIV (TD),
    .CLICK_MS (C_MS),
    .NOTE_MS  (N_MS),
    .GAP_MS   (G_MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_pressed (key_pressed),
    .jingle_req  (jingle_req),
    .jingle_sel  (jingle_sel),
    .music_en    (music_en),
    .music_note  (music_note),
    .note_out    (note_out),
    .active_src  (active_src),
    .busy        (busy),
    .jingle_done (jingle_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] note;
    logic [1:0] src;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic [2:0] note;
    int         len;
  } seg_t;

  obs_t expq[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Reference: playback is a queue of (note, cycles) segments
  seg_t segq[$];
  int   mode = 0;
  int   rem  = 0;
  logic kprev = 1'b0;

  function automatic logic [2:0] tbl_note(input bit w, input int i);
    logic [2:0] wt [4];
    logic [2:0] lt [4];
    wt = '{3'd4, 3'd1, 3'd3, 3'd5};
    lt = '{3'd3, 3'd1, 3'd2, 3'd4};
    return w ? wt[i] : lt[i];
  endfunction

  initial forever begin
    obs_t e;
    bit   rise;
    bit   dn;
    @(posedge clk);
    e  = '0;
    dn = 0;
    if (!rst_n) begin
      mode = 0;
      segq.delete();
      kprev = 1'b0;
    end else begin
      rise  = key_pressed && !kprev;
      kprev = key_pressed;
      if (jingle_req && (jingle_sel == 2'b01 || jingle_sel == 2'b10)) begin
        segq.delete();
        for (int i = 0; i < 4; i++) begin
          segq.push_back('{tbl_note(jingle_sel == 2'b01, i), NOT_LEN});
`ifdef TONE_ARB_GAP_EN
          if (i < 3) segq.push_back('{3'd0, GAP_LEN});
`endif
        end
        mode = 2;
        rem  = segq[0].len;
      end else if (rise && mode != 2) begin
        segq.delete();
        segq.push_back('{3'd1, CLK_LEN});
        mode = 1;
        rem  = CLK_LEN;
      end else if (mode != 0) begin
        rem--;
        if (rem == 0) begin
          void'(segq.pop_front());
          if (segq.size() == 0) begin
            dn   = (mode == 2);
            mode = 0;
          end else begin
            rem = segq[0].len;
          end
        end
      end
      if (mode != 0) begin
        e.note = segq[0].note;
        e.src  = (mode == 1) ? 2'd2 : 2'd3;
        e.busy = 1'b1;
      end else begin
        e.note = music_en ? music_note : 3'd0;
        e.src  = music_en ? 2'd1 : 2'd0;
      end
      e.done = dn;
    end
    expq.push_back(e);
  end

  initial forever begin
    obs_t e;
    obs_t a;
    @(posedge clk);
    #1;
    a = '{note_out, active_src, busy, jingle_done};
    chk_cnt++;
    if (expq.size() == 0) begin
      $display("FAIL scoreboard_empty t=%0t actual=%b", $time, a);
    end else begin
      e = expq.pop_front();
      if (a === e) begin
        pass_cnt++;
      end else begin
        $display("FAIL outputs t=%0t actual note=%0d src=%0d busy=%b done=%b required note=%0d src=%0d busy=%b done=%b",
                 $time, a.note, a.src, a.busy, a.done,
                 e.note, e.src, e.busy, e.done);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic jpulse(input logic [1:0] sel);
    jingle_sel = sel;
    jingle_req = 1'b1;
    cyc(1);
    jingle_req = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    music_en   = 1'b1;
    music_note = 3'd3;
    cyc(5);
    music_en = 1'b0;
    cyc(3);
    music_en    = 1'b1;
    key_pressed = 1'b1;
    cyc(70);
    key_pressed = 1'b0;
    cyc(5);
    jpulse(2'b01);
    cyc(140);
    jpulse(2'b11);
    cyc(5);
    key_pressed = 1'b1;
    cyc(20);
    key_pressed = 1'b0;
    cyc(1);
    key_pressed = 1'b1;
    cyc(30);
    jpulse(2'b10);
    key_pressed = 1'b0;
    cyc(150);
    jpulse(2'b01);
    cyc(10);
    key_pressed = 1'b1;
    cyc(3);
    key_pressed = 1'b0;
    cyc(160);
    key_pressed = 1'b1;
    jpulse(2'b10);
    key_pressed = 1'b0;
    cyc(60);
    jpulse(2'b01);
    cyc(5);
    jpulse(2'b10);
    cyc(40);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) key_pressed = ~key_pressed;
      if ($urandom_range(0, 99) == 0) music_en = ~music_en;
      music_note = 3'($urandom_range(0, 7));
      jingle_sel = 2'($urandom_range(0, 3));
      jingle_req = ($urandom_range(0, 179) == 0);
      rst_n      = ($urandom_range(0, 1499) != 0);
      cyc(1);
    end
    jingle_req = 1'b0;
    rst_n      = 1'b1;
    cyc(3);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
